// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared state type, ALU opcodes and sizing for the multiply/divide sequencer
package muldiv_pkg;
  localparam int WIDTH = 24;
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [3:0] ALU_OP_ADD = 4'b0000;
  localparam logic [3:0] ALU_OP_SUB = 4'b0100;
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
endpackage

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: request, result and ALU-side signals of the multiply/divide sequencer
interface muldiv_sequencer_if;
  import muldiv_pkg::*;
  logic start, isDiv, busy, done, divByZero, opError;
  logic [WIDTH-1:0] opA, opB, resLo, resHi, aluA, aluB, aluOut;
  logic [3:0] aluOp;
  modport master (
    output start, isDiv, opA, opB, aluOut,
    input  busy, done, resLo, resHi, divByZero, opError, aluA, aluB, aluOp
  );
  modport slave (
    input  start, isDiv, opA, opB, aluOut,
    output busy, done, resLo, resHi, divByZero, opError, aluA, aluB, aluOp
  );
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring divide step; divide path present only with MULDIV_DIV_EN
module muldiv_step
  import muldiv_pkg::*;
(
`ifdef MULDIV_DIV_EN
  input  logic             is_div,
`endif
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] opnd,
  input  logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  output logic [WIDTH-1:0] hi_n,
  output logic [WIDTH-1:0] lo_n
);
  logic c;
`ifdef MULDIV_DIV_EN
  logic [WIDTH:0] sh;
  logic nb, ge;
  // divide: shift the next dividend bit into the remainder and trial-subtract the divisor
  always_comb begin
    sh = {hi, lo[WIDTH-1]};
    nb = (sh[WIDTH-1] & ~opnd[WIDTH-1]) | ((sh[WIDTH-1] | ~opnd[WIDTH-1]) & ~alu_out[WIDTH-1]);
    ge = sh[WIDTH] | nb;
  end
  // ALU operands depend only on registers so the external ALU closes no loop
  always_comb begin
    alu_a = is_div ? sh[WIDTH-1:0] : hi;
    alu_b = opnd;
    alu_op = is_div ? ALU_OP_SUB : ALU_OP_ADD;
  end
`else
  // ALU operands depend only on registers so the external ALU closes no loop
  always_comb begin
    alu_a = hi;
    alu_b = opnd;
    alu_op = ALU_OP_ADD;
  end
`endif
  // multiply adds the multiplicand when the low bit is set, then shifts {P,L} right with the carry
  always_comb begin
    c = (hi[WIDTH-1] & opnd[WIDTH-1]) | ((hi[WIDTH-1] | opnd[WIDTH-1]) & ~alu_out[WIDTH-1]);
    hi_n = lo[0] ? {c, alu_out[WIDTH-1:1]} : {1'b0, hi[WIDTH-1:1]};
    lo_n = {lo[0] ? alu_out[0] : hi[0], lo[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    hi_n = is_div ? (ge ? alu_out : sh[WIDTH-1:0]) : hi_n;
    lo_n = is_div ? {lo[WIDTH-2:0], ge} : lo_n;
`endif
  end
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: time-shares the ALU for 24-step multiply and divide; MULDIV_DIV_EN compiles in the divide path
module muldiv_sequencer
  import muldiv_pkg::*;
(
  input logic clk,
  input logic rst,
  muldiv_sequencer_if.slave s
);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d, res_hi_q, res_hi_d;
  logic [WIDTH-1:0] alu_a, alu_b, hi_n, lo_n;
  logic [3:0] alu_op;
  logic busy_q, busy_d, done_q, done_d, dbz_q, dbz_d, err_q, err_d;
  logic acc, dz, err;
`ifdef MULDIV_DIV_EN
  logic div_q, div_d;
  assign dz = s.isDiv && s.opB == '0;
  assign err = 1'b0;
`else
  assign dz = 1'b0;
  assign err = s.isDiv;
`endif
  assign acc = s.start && state_q != ITER;
  muldiv_step u_step (
`ifdef MULDIV_DIV_EN
    .is_div(div_q),
`endif
    .hi(hi_q),
    .lo(lo_q),
    .opnd(opnd_q),
    .alu_out(s.aluOut),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_op(alu_op),
    .hi_n(hi_n),
    .lo_n(lo_n)
  );
  assign s.aluA = busy_q ? alu_a : '0;
  assign s.aluB = busy_q ? alu_b : '0;
  assign s.aluOp = busy_q ? alu_op : ALU_OP_ADD;
  assign s.busy = busy_q;
  assign s.done = done_q;
  assign s.resLo = res_lo_q;
  assign s.resHi = res_hi_q;
  assign s.divByZero = dbz_q;
  assign s.opError = err_q;
  // accept requests from IDLE/DONE, step once per ITER cycle, publish results on entering DONE
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    hi_d = hi_q;
    lo_d = lo_q;
    opnd_d = opnd_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    dbz_d = dbz_q;
    err_d = err_q;
`ifdef MULDIV_DIV_EN
    div_d = div_q;
`endif
    if (acc) begin
      dbz_d = dz;
      err_d = err;
      if (dz || err) begin
        state_d = DONE;
        res_lo_d = dz ? '1 : '0;
        res_hi_d = dz ? s.opA : '0;
      end else begin
        state_d = ITER;
        cnt_d = '0;
        hi_d = '0;
        lo_d = s.opB;
        opnd_d = s.opA;
`ifdef MULDIV_DIV_EN
        div_d = s.isDiv;
        lo_d = s.isDiv ? s.opA : s.opB;
        opnd_d = s.isDiv ? s.opB : s.opA;
`endif
      end
    end else if (state_q == ITER) begin
      hi_d = hi_n;
      lo_d = lo_n;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        state_d = DONE;
        res_hi_d = hi_n;
        res_lo_d = lo_n;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
    busy_d = state_d == ITER;
    done_d = state_d == DONE;
  end
  // state, datapath and registered status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      opnd_q <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dbz_q <= 1'b0;
      err_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      div_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      opnd_q <= opnd_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      busy_q <= busy_d;
      done_q <= done_d;
      dbz_q <= dbz_d;
      err_q <= err_d;
`ifdef MULDIV_DIV_EN
      div_q <= div_d;
`endif
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed tests plus an arithmetic reference model checked every cycle
module tb_muldiv_sequencer;
  logic clk, rst, chk_en;
  int n_cmp, n_bad;
  muldiv_sequencer_if m();
  muldiv_sequencer dut (.clk(clk), .rst(rst), .s(m));
  assign m.aluOut = m.aluOp == 4'b0100 ? m.aluA - m.aluB : m.aluA + m.aluB;
  logic e_busy, e_done, e_dbz, e_err, e_div;
  logic [23:0] e_lo, e_hi, e_opnd, p_lo, p_hi;
  int left;
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    if (rst) begin
      e_busy <= 0; e_done <= 0; e_dbz <= 0; e_err <= 0; e_div <= 0;
      e_lo <= 0; e_hi <= 0; e_opnd <= 0; left <= 0;
    end else if (m.start && !e_busy) begin
      e_dbz <= 0; e_err <= 0; e_done <= 0;
`ifdef MULDIV_DIV_EN
      if (m.isDiv && m.opB == 0) begin
        e_dbz <= 1; e_done <= 1; e_lo <= 24'hFFFFFF; e_hi <= m.opA;
      end
`else
      if (m.isDiv) begin
        e_err <= 1; e_done <= 1; e_lo <= 0; e_hi <= 0;
      end
`endif
      else begin
        e_busy <= 1; left <= 24; e_div <= m.isDiv;
        e_opnd <= m.isDiv ? m.opB : m.opA;
        if (m.isDiv) begin
          p_lo <= m.opA / m.opB; p_hi <= m.opA % m.opB;
        end else begin
          {p_hi, p_lo} <= 48'(m.opA) * 48'(m.opB);
        end
      end
    end else if (e_busy) begin
      left <= left - 1;
      if (left == 1) begin
        e_busy <= 0; e_done <= 1; e_lo <= p_lo; e_hi <= p_hi;
      end
    end else begin
      e_done <= 0;
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 48'(m.busy), 48'(e_busy));
      chk("done", 48'(m.done), 48'(e_done));
      chk("resLo", 48'(m.resLo), 48'(e_lo));
      chk("resHi", 48'(m.resHi), 48'(e_hi));
      chk("divByZero", 48'(m.divByZero), 48'(e_dbz));
      chk("opError", 48'(m.opError), 48'(e_err));
      chk("aluOp", 48'(m.aluOp), 48'(e_busy && e_div ? 4'b0100 : 4'b0000));
      chk("aluB", 48'(m.aluB), 48'(e_busy ? e_opnd : 24'd0));
      if (!e_busy) chk("aluA idle", 48'(m.aluA), 48'd0);
    end
  end
  task automatic wait_done(output int k);
    k = 1;
    while (!m.done && k < 40) begin
      @(posedge clk); #2;
      k++;
    end
  endtask
  task automatic op(input string nm, input logic d, input logic [23:0] a, input logic [23:0] b,
                    input logic [23:0] elo, input logic [23:0] ehi, input int elat,
                    input logic edz, input logic eer);
    int k;
    m.start = 1; m.isDiv = d; m.opA = a; m.opB = b;
    @(posedge clk); #2;
    m.start = 0; m.isDiv = 0; m.opA = 24'h5A5A5A; m.opB = 24'hA5A5A5;
    wait_done(k);
    chk({nm, " latency"}, 48'(k), 48'(elat));
    chk({nm, " lo"}, 48'(m.resLo), 48'(elo));
    chk({nm, " hi"}, 48'(m.resHi), 48'(ehi));
    chk({nm, " dbz"}, 48'(m.divByZero), 48'(edz));
    chk({nm, " err"}, 48'(m.opError), 48'(eer));
  endtask
  initial begin
    int k;
    n_cmp = 0; n_bad = 0; chk_en = 0;
    rst = 1; m.start = 0; m.isDiv = 0; m.opA = 0; m.opB = 0;
    repeat (2) @(posedge clk);
    #2;
    chk_en = 1;
    chk("reset busy", 48'(m.busy), 48'd0);
    chk("reset done", 48'(m.done), 48'd0);
    chk("reset resLo", 48'(m.resLo), 48'd0);
    chk("reset aluA", 48'(m.aluA), 48'd0);
    rst = 0;
    @(posedge clk); #2;
    op("mul 3x5", 0, 24'd3, 24'd5, 24'd15, 24'd0, 25, 0, 0);
    @(posedge clk); #2;
    op("mul max", 0, 24'hFFFFFF, 24'hFFFFFF, 24'h000001, 24'hFFFFFE, 25, 0, 0);
`ifdef MULDIV_DIV_EN
    op("div 100/7", 1, 24'd100, 24'd7, 24'd14, 24'd2, 25, 0, 0);
    op("div max/1", 1, 24'hFFFFFF, 24'd1, 24'hFFFFFF, 24'd0, 25, 0, 0);
    @(posedge clk); #2;
    op("div 800000/max", 1, 24'h800000, 24'hFFFFFF, 24'd0, 24'h800000, 25, 0, 0);
    op("div 5/0", 1, 24'd5, 24'd0, 24'hFFFFFF, 24'd5, 1, 1, 0);
    op("mul after dbz", 0, 24'd2, 24'd3, 24'd6, 24'd0, 25, 0, 0);
`else
    op("div disabled", 1, 24'd100, 24'd7, 24'd0, 24'd0, 1, 0, 1);
    op("mul after err", 0, 24'd2, 24'd3, 24'd6, 24'd0, 25, 0, 0);
`endif
    @(posedge clk); #2;
    m.start = 1; m.isDiv = 0; m.opA = 24'd7; m.opB = 24'd9;
    @(posedge clk); #2;
    wait_done(k);
    chk("held start latency", 48'(k), 48'd25);
    chk("held start lo", 48'(m.resLo), 48'd63);
    m.opA = 24'd11; m.opB = 24'd13;
    @(posedge clk); #2;
    m.start = 0;
    wait_done(k);
    chk("b2b latency", 48'(k), 48'd25);
    chk("b2b lo", 48'(m.resLo), 48'd143);
    m.start = 1; m.opA = 24'd3; m.opB = 24'd5;
    @(posedge clk); #2;
    m.start = 0;
    repeat (9) @(posedge clk);
    #2;
    chk("busy before rst", 48'(m.busy), 48'd1);
    rst = 1;
    @(posedge clk); #2;
    chk("rst busy", 48'(m.busy), 48'd0);
    chk("rst resLo", 48'(m.resLo), 48'd0);
    chk("rst aluB", 48'(m.aluB), 48'd0);
    m.start = 1;
    @(posedge clk); #2;
    chk("rst beats start", 48'(m.busy), 48'd0);
    rst = 0; m.start = 0;
    @(posedge clk); #2;
    op("mul 0xmax", 0, 24'd0, 24'hFFFFFF, 24'd0, 24'd0, 25, 0, 0);
    op("mul 1000x1000", 0, 24'd1000, 24'd1000, 24'h0F4240, 24'd0, 25, 0, 0);
    repeat (3) @(posedge clk);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
